// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: default sizes and the per-entry record,
// used by decode, the functional units and the buffer itself.
package reorder_buffer_pkg;

    localparam int ROB_REG_ADDRESS_SIZE = 5;
    localparam int ROB_REG_SIZE         = 32;
    localparam int ROB_ID_SIZE          = 3;

    // Status bits of one entry; dest and value are held alongside, sized by the
    // instantiating module's parameters.
    typedef struct packed {
        logic valid;
        logic done;
        logic w;
    } rob_flags_t;

    // Full entry record at the default sizes, for stages that pass entries around.
    typedef struct packed {
        rob_flags_t                      flags;
        logic [ROB_REG_ADDRESS_SIZE-1:0] dest;
        logic [ROB_REG_SIZE-1:0]         value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_dep_search.sv
// Youngest-match search: finds the most recently allocated valid entry that
// writes the looked-up register.
module rob_dep_search #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int ID_SIZE          = 3
) (
    input  logic [(1<<ID_SIZE)-1:0]                       i_valid,
    input  logic [(1<<ID_SIZE)-1:0]                       i_w,
    input  logic [(1<<ID_SIZE)-1:0][REG_ADDRESS_SIZE-1:0] i_dest,
    input  logic [ID_SIZE-1:0]                            i_head,
    input  logic                                          i_skip_head,
    input  logic [REG_ADDRESS_SIZE-1:0]                   i_addr,
    output logic                                          o_hit,
    output logic [ID_SIZE-1:0]                            o_id
);
    localparam int DEPTH = 1 << ID_SIZE;

    logic [ID_SIZE-1:0] w_idx;

    // Walk oldest to youngest from the head; the last match seen is the youngest.
    always_comb begin
        o_hit = 1'b0;
        o_id  = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + ID_SIZE'(k);
            if (i_valid[w_idx] && i_w[w_idx] && (i_dest[w_idx] == i_addr) &&
                !((k == 0) && i_skip_head)) begin
                o_hit = 1'b1;
                o_id  = w_idx;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer with two writeback ports, two dependency
// lookup ports and branch flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
    parameter int REG_SIZE         = ROB_REG_SIZE,
    parameter int ID_SIZE          = ROB_ID_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rob_alloc,
    input  logic [REG_ADDRESS_SIZE-1:0] rob_alloc_dest,
    input  logic                        rob_alloc_w,
    output logic [ID_SIZE-1:0]          rob_tail,
    output logic                        rob_stall,
    input  logic                        rob_wb0_valid,
    input  logic [ID_SIZE-1:0]          rob_wb0_id,
    input  logic [REG_SIZE-1:0]         rob_wb0_value,
    input  logic                        rob_wb1_valid,
    input  logic [ID_SIZE-1:0]          rob_wb1_id,
    input  logic [REG_SIZE-1:0]         rob_wb1_value,
    input  logic [REG_ADDRESS_SIZE-1:0] rob_dAddr1,
    input  logic [REG_ADDRESS_SIZE-1:0] rob_dAddr2,
    output logic                        rob_dependency1,
    output logic                        rob_dependency2,
    output logic                        rob_resolved1,
    output logic                        rob_resolved2,
    output logic [REG_SIZE-1:0]         rob_dValue1,
    output logic [REG_SIZE-1:0]         rob_dValue2,
    output logic                        rob_We,
    output logic [REG_ADDRESS_SIZE-1:0] rob_Wat,
    output logic [REG_SIZE-1:0]         rob_Wvalue,
    input  logic                        rob_flush
);
    localparam int DEPTH = 1 << ID_SIZE;

    rob_flags_t [DEPTH-1:0]                       r_flags;
    logic       [DEPTH-1:0][REG_ADDRESS_SIZE-1:0] r_dest;
    logic       [DEPTH-1:0][REG_SIZE-1:0]         r_value;
    logic [ID_SIZE-1:0]                           r_head;
    logic [ID_SIZE-1:0]                           r_tail;
    logic [ID_SIZE:0]                             r_count;

    logic                        w_alloc;
    logic                        w_retire;
    logic [ID_SIZE-1:0]          w_head_next;
    logic [DEPTH-1:0]            w_valid_vec;
    logic [DEPTH-1:0]            w_w_vec;
    logic [1:0][REG_ADDRESS_SIZE-1:0] w_addr;
    logic [1:0]                  w_hit;
    logic [1:0][ID_SIZE-1:0]     w_id;
    logic [1:0]                  w_res;
    logic [1:0][REG_SIZE-1:0]    w_dval;

    assign rob_stall   = (r_count == (ID_SIZE+1)'(DEPTH));
    assign rob_tail    = r_tail;
    assign w_alloc     = rob_alloc && !rob_stall && !rob_flush;
    assign w_retire    = r_flags[r_head].valid && r_flags[r_head].done;
    assign w_head_next = r_head + ID_SIZE'(w_retire);

    assign rob_We     = w_retire && r_flags[r_head].w;
    assign rob_Wat    = r_dest[r_head];
    assign rob_Wvalue = r_value[r_head];

    always_comb begin
        w_valid_vec = '0;
        w_w_vec     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_vec[i] = r_flags[i].valid;
            w_w_vec[i]     = r_flags[i].w;
        end
    end

    assign w_addr = {rob_dAddr2, rob_dAddr1};

    // The retiring head is skipped: the register bank sees its write this cycle.
    for (genvar p = 0; p < 2; p++) begin : g_search
        rob_dep_search #(
            .REG_ADDRESS_SIZE(REG_ADDRESS_SIZE),
            .ID_SIZE         (ID_SIZE)
        ) u_search (
            .i_valid    (w_valid_vec),
            .i_w        (w_w_vec),
            .i_dest     (r_dest),
            .i_head     (r_head),
            .i_skip_head(w_retire),
            .i_addr     (w_addr[p]),
            .o_hit      (w_hit[p]),
            .o_id       (w_id[p])
        );
    end

    // Same-cycle writebacks forward into the lookup, port 0 taking priority.
    always_comb begin
        w_res  = '0;
        w_dval = '0;
        for (int p = 0; p < 2; p++) begin
            if (w_hit[p]) begin
                if (rob_wb0_valid && (rob_wb0_id == w_id[p])) begin
                    w_res[p]  = 1'b1;
                    w_dval[p] = rob_wb0_value;
                end else if (rob_wb1_valid && (rob_wb1_id == w_id[p])) begin
                    w_res[p]  = 1'b1;
                    w_dval[p] = rob_wb1_value;
                end else begin
                    w_res[p]  = r_flags[w_id[p]].done;
                    w_dval[p] = r_value[w_id[p]];
                end
            end
        end
    end

    assign rob_dependency1 = w_hit[0];
    assign rob_dependency2 = w_hit[1];
    assign rob_resolved1   = w_res[0];
    assign rob_resolved2   = w_res[1];
    assign rob_dValue1     = w_dval[0];
    assign rob_dValue2     = w_dval[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_flags[i].valid) begin
                    if (rob_wb0_valid && (rob_wb0_id == ID_SIZE'(i))) begin
                        r_flags[i].done <= 1'b1;
                        r_value[i]      <= rob_wb0_value;
                    end else if (rob_wb1_valid && (rob_wb1_id == ID_SIZE'(i))) begin
                        r_flags[i].done <= 1'b1;
                        r_value[i]      <= rob_wb1_value;
                    end
                end
            end
            if (w_retire)
                r_flags[r_head].valid <= 1'b0;
            r_head <= w_head_next;
            if (rob_flush) begin
                for (int i = 0; i < DEPTH; i++)
                    r_flags[i].valid <= 1'b0;
                r_tail  <= w_head_next;
                r_count <= '0;
            end else begin
                if (w_alloc) begin
                    r_flags[r_tail] <= '{valid: 1'b1, done: 1'b0, w: rob_alloc_w};
                    r_dest[r_tail]  <= rob_alloc_dest;
                    r_tail          <= r_tail + ID_SIZE'(1);
                end
                r_count <= r_count + (ID_SIZE+1)'(w_alloc) - (ID_SIZE+1)'(w_retire);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer against a queue-based reference model.
module tb_reorder_buffer;
    localparam int A = 5;
    localparam int R = 32;
    localparam int ID = 3;
    localparam int N = 1 << ID;

    logic          clk;
    logic          reset;
    logic          rob_alloc;
    logic [A-1:0]  rob_alloc_dest;
    logic          rob_alloc_w;
    logic [ID-1:0] rob_tail;
    logic          rob_stall;
    logic          rob_wb0_valid, rob_wb1_valid;
    logic [ID-1:0] rob_wb0_id, rob_wb1_id;
    logic [R-1:0]  rob_wb0_value, rob_wb1_value;
    logic [A-1:0]  rob_dAddr1, rob_dAddr2;
    logic          rob_dependency1, rob_dependency2;
    logic          rob_resolved1, rob_resolved2;
    logic [R-1:0]  rob_dValue1, rob_dValue2;
    logic          rob_We;
    logic [A-1:0]  rob_Wat;
    logic [R-1:0]  rob_Wvalue;
    logic          rob_flush;

    reorder_buffer #(.REG_ADDRESS_SIZE(A), .REG_SIZE(R), .ID_SIZE(ID)) dut (
        .clk(clk), .reset(reset),
        .rob_alloc(rob_alloc), .rob_alloc_dest(rob_alloc_dest), .rob_alloc_w(rob_alloc_w),
        .rob_tail(rob_tail), .rob_stall(rob_stall),
        .rob_wb0_valid(rob_wb0_valid), .rob_wb0_id(rob_wb0_id), .rob_wb0_value(rob_wb0_value),
        .rob_wb1_valid(rob_wb1_valid), .rob_wb1_id(rob_wb1_id), .rob_wb1_value(rob_wb1_value),
        .rob_dAddr1(rob_dAddr1), .rob_dAddr2(rob_dAddr2),
        .rob_dependency1(rob_dependency1), .rob_dependency2(rob_dependency2),
        .rob_resolved1(rob_resolved1), .rob_resolved2(rob_resolved2),
        .rob_dValue1(rob_dValue1), .rob_dValue2(rob_dValue2),
        .rob_We(rob_We), .rob_Wat(rob_Wat), .rob_Wvalue(rob_Wvalue),
        .rob_flush(rob_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: program-order queue of live tags plus per-tag fields.
    int          q[$];
    int          m_head, m_tail;
    bit          m_done[N];
    bit          m_w[N];
    int          m_dest[N];
    logic [31:0] m_val[N];

    function automatic bit in_q(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_lookup(input int a, output logic dep, output logic res,
                              output logic [31:0] val);
        int lo;
        dep = 1'b0; res = 1'b0; val = '0;
        lo = (q.size() > 0 && m_done[q[0]]) ? 1 : 0;
        for (int i = q.size() - 1; i >= lo; i--) begin
            if (m_w[q[i]] && m_dest[q[i]] == a) begin
                int t;
                t = q[i];
                dep = 1'b1;
                if (rob_wb0_valid && int'(rob_wb0_id) == t) begin
                    res = 1'b1; val = rob_wb0_value;
                end else if (rob_wb1_valid && int'(rob_wb1_id) == t) begin
                    res = 1'b1; val = rob_wb1_value;
                end else begin
                    res = m_done[t]; val = m_val[t];
                end
                break;
            end
        end
    endtask

    function automatic int pick_id();
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
            return q[$urandom_range(0, q.size() - 1)];
        return int'($urandom_range(0, N - 1));
    endfunction

    logic        e_stall, e_ret, e_we, e_dep, e_res;
    logic [31:0] e_val;
    int          p_alloc, p_wb;

    initial begin
        reset = 1'b1; rob_alloc = 1'b0; rob_alloc_dest = '0; rob_alloc_w = 1'b0;
        rob_wb0_valid = 1'b0; rob_wb0_id = '0; rob_wb0_value = '0;
        rob_wb1_valid = 1'b0; rob_wb1_id = '0; rob_wb1_value = '0;
        rob_dAddr1 = '0; rob_dAddr2 = '0; rob_flush = 1'b0;
        m_head = 0; m_tail = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_tail", 32'(rob_tail), 0);
        chk("rst_stall", 32'(rob_stall), 0);
        chk("rst_we", 32'(rob_We), 0);
        chk("rst_dep1", 32'(rob_dependency1), 0);
        chk("rst_dep2", 32'(rob_dependency2), 0);
        chk("rst_res1", 32'(rob_resolved1), 0);
        chk("rst_res2", 32'(rob_resolved2), 0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            case ((cyc / 500) % 4)
                0: begin p_alloc = 90; p_wb = 20; end
                1: begin p_alloc = 50; p_wb = 60; end
                2: begin p_alloc = 30; p_wb = 85; end
                default: begin p_alloc = 70; p_wb = 40; end
            endcase
            reset          = ($urandom_range(0, 99) == 0);
            rob_flush      = ($urandom_range(0, 99) < 3);
            rob_alloc      = ($urandom_range(0, 99) < p_alloc);
            rob_alloc_w    = ($urandom_range(0, 4) != 0);
            rob_alloc_dest = A'($urandom_range(0, 3));
            rob_wb0_valid  = ($urandom_range(0, 99) < p_wb);
            rob_wb0_id     = ID'(pick_id());
            rob_wb0_value  = $urandom;
            rob_wb1_valid  = ($urandom_range(0, 99) < p_wb);
            rob_wb1_id     = ($urandom_range(0, 7) == 0) ? rob_wb0_id : ID'(pick_id());
            rob_wb1_value  = $urandom;
            rob_dAddr1     = A'($urandom_range(0, 3));
            rob_dAddr2     = A'($urandom_range(0, 3));
            #1;
            e_stall = (q.size() == N);
            e_ret   = (q.size() > 0) && m_done[q[0]];
            e_we    = e_ret && m_w[q[0]];
            chk("stall", 32'(rob_stall), 32'(e_stall));
            chk("tail", 32'(rob_tail), 32'(m_tail));
            chk("we", 32'(rob_We), 32'(e_we));
            if (e_we) begin
                chk("wat", 32'(rob_Wat), 32'(m_dest[q[0]]));
                chk("wvalue", rob_Wvalue, m_val[q[0]]);
            end
            ref_lookup(int'(rob_dAddr1), e_dep, e_res, e_val);
            chk("dep1", 32'(rob_dependency1), 32'(e_dep));
            chk("res1", 32'(rob_resolved1), 32'(e_res));
            if (e_res) chk("dval1", rob_dValue1, e_val);
            ref_lookup(int'(rob_dAddr2), e_dep, e_res, e_val);
            chk("dep2", 32'(rob_dependency2), 32'(e_dep));
            chk("res2", 32'(rob_resolved2), 32'(e_res));
            if (e_res) chk("dval2", rob_dValue2, e_val);

            @(posedge clk);
            if (reset) begin
                q.delete();
                m_head = 0; m_tail = 0;
            end else begin
                if (rob_wb0_valid && in_q(int'(rob_wb0_id))) begin
                    m_done[rob_wb0_id] = 1'b1; m_val[rob_wb0_id] = rob_wb0_value;
                end
                if (rob_wb1_valid && in_q(int'(rob_wb1_id)) &&
                    !(rob_wb0_valid && rob_wb0_id == rob_wb1_id)) begin
                    m_done[rob_wb1_id] = 1'b1; m_val[rob_wb1_id] = rob_wb1_value;
                end
                if (e_ret) begin
                    void'(q.pop_front());
                    m_head = (m_head + 1) % N;
                end
                if (rob_flush) begin
                    q.delete();
                    m_tail = m_head;
                end else if (rob_alloc && !e_stall) begin
                    m_w[m_tail]    = rob_alloc_w;
                    m_dest[m_tail] = int'(rob_alloc_dest);
                    m_done[m_tail] = 1'b0;
                    q.push_back(m_tail);
                    m_tail = (m_tail + 1) % N;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
- REQ-001 SHALL have parameters: REG_ADDRESS_SIZE, default 5, register index width; REG_SIZE, default 32, data width; ID_SIZE, default 3, entry tag width, giving 2^ID_SIZE entries.
- REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-004 SHALL have port rob_alloc, input, 1, decode issues one instruction this cycle.
- REQ-005 SHALL have ports rob_alloc_dest, input, REG_ADDRESS_SIZE, and rob_alloc_w, input, 1: destination register and write-enable of the issued instruction.
- REQ-006 SHALL have port rob_tail, output, ID_SIZE, tag that the next allocation receives.
- REQ-007 SHALL have port rob_stall, output, 1, buffer full, so no allocation is accepted.
- REQ-008 SHALL have ports rob_wb0_valid/rob_wb1_valid, input, 1; rob_wb0_id/rob_wb1_id, input, ID_SIZE; rob_wb0_value/rob_wb1_value, input, REG_SIZE: the two unit completion ports.
- REQ-009 SHALL have ports rob_dAddr1/rob_dAddr2, input, REG_ADDRESS_SIZE, the source registers being looked up.
- REQ-010 SHALL have ports rob_dependency1/2, output, 1; rob_resolved1/2, output, 1; rob_dValue1/2, output, REG_SIZE: the lookup results.
- REQ-011 SHALL have ports rob_We, output, 1; rob_Wat, output, REG_ADDRESS_SIZE; rob_Wvalue, output, REG_SIZE: the in-order register-bank commit write.
- REQ-012 SHALL have port rob_flush, input, 1, taken branch: discard every uncommitted entry.

Function
- REQ-013 SHALL hold per entry: valid, done, w, dest, value; head and tail pointers of ID_SIZE bits that wrap modulo 2^ID_SIZE; count from 0 to 2^ID_SIZE.
- REQ-014 SHALL assert rob_stall combinationally when count == 2^ID_SIZE.
- REQ-015 SHALL, when rob_alloc && !rob_stall && !rob_flush, write entry[tail] as {valid=1, done=0, w, dest} and increment tail; otherwise rob_alloc SHALL be ignored.
- REQ-016 SHALL, on rob_wbN_valid for a valid entry, set done=1 and value=rob_wbN_value at the edge; a writeback to an invalid entry SHALL be ignored. If both ports name the same id, port 0 SHALL win.
- REQ-017 SHALL drive the commit outputs combinationally from the head: rob_We = head valid && done && w; rob_Wat = dest and rob_Wvalue = value (don't-care when rob_We=0).
- REQ-018 SHALL retire the head (clear valid, increment head) when it is valid and done, whether w is 1 or 0; at most one retirement per cycle; none when count==0.
- REQ-019 SHALL update count by +1 for alloc, -1 for retire, and 0 when both occur; alloc while full is blocked even if a retirement happens the same cycle.
- REQ-020 SHALL compute rob_dependencyK = 1 when some valid entry has w=1 && dest==rob_dAddrK; the youngest such entry (closest to tail-1) is selected.
- REQ-021 SHALL drive rob_resolvedK = selected entry done, or a same-cycle writeback targeting its id. rob_dValueK SHALL be that writeback value (port 0 first), else the entry value.
- REQ-022 SHALL exclude the head entry from lookup while it is being retired, because the register bank write-through covers it.
- REQ-023 SHALL, on rob_flush, keep the retirement of the current head if it is done. All other entries SHALL be invalidated, with tail set to the post-retire head and count set to 0, taking effect at the edge.
- REQ-024 SHALL have allocation-to-lookup visibility of 1 cycle and writeback-to-commit latency of 1 cycle minimum.

Reset
- REQ-025 SHALL on reset clear all valid/done bits and set head=tail=count=0. Outputs SHALL be rob_tail=0, rob_stall=0, rob_We=0, rob_dependency1/2=0, rob_resolved1/2=0. Reset SHALL override alloc, writeback and flush in the same cycle, including mid-operation.

Structure
- REQ-026 SHALL take the parameter defaults and the entry record layout from a shared package used by the decode stage and the functional units.
- REQ-027 SHALL instantiate the youngest-match search as sub-module rob_dep_search, used twice, once per lookup port.

Verification
- REQ-028 Alloc r3 (w=1) at tag 0, lookup r3 the next cycle -> dependency1=1, resolved1=0; wb0 id0 value 0x55 -> resolved1=1, dValue1=0x55 the same cycle; next cycle rob_We=1, Wat=3, Wvalue=0x55.
- REQ-029 Alloc 8 entries with ID_SIZE=3 -> rob_stall=1; a 9th alloc is ignored and rob_tail stays 0 after wrap; complete the head -> stall drops the cycle after retirement.
- REQ-030 Alloc r5 twice (tags 0,1), complete tag1 with 0xB then tag0 with 0xA -> lookup r5 returns 0xB; commits occur in order: 0xA then 0xB.
- REQ-031 Alloc an entry with w=0 and complete it -> it retires with rob_We=0 throughout.
- REQ-032 Four entries pending with the head done, assert rob_flush -> head commits, count=0, tail=head; a later writeback to a flushed tag changes nothing.
- REQ-033 Assert reset with 5 entries pending -> all outputs hit their reset values on the next cycle.
